// File: rtl/life_pkg.sv
// Shared sizing and state encoding for the Life board read-out path.
// Defaults describe the 16x16 board produced by the stepper.
package life_pkg;

    localparam int LIFE_ROWS = 16;
    localparam int LIFE_COLS = 16;
    localparam int PTR_W     = $clog2(LIFE_ROWS);
    localparam int POP_W     = $clog2(LIFE_ROWS * LIFE_COLS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/row_popcount.sv
// Combinational live-cell count for one board row.
// The count is one bit wider than clog2(COLS) so a fully live row fits.
module row_popcount #(
    parameter int COLS = 16
) (
    input  logic [COLS-1:0]          row,
    output logic [$clog2(COLS):0]    count
);

    localparam int CNT_W = $clog2(COLS) + 1;

    always_comb begin
        count = '0;
        for (int i = 0; i < COLS; i++) begin
            count = count + CNT_W'(row[i]);
        end
    end

endmodule

// File: rtl/life_board_reader.sv
// Snapshots the Life board on start and streams it one row per valid/ready
// transfer, reporting the frame's live-cell population with a done pulse.
module life_board_reader
    import life_pkg::*;
#(
    parameter int ROWS = LIFE_ROWS,
    parameter int COLS = LIFE_COLS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ROWS*COLS-1:0]         board,
    output logic                         busy,
    output logic                         row_valid,
    input  logic                         row_ready,
    output logic [COLS-1:0]              row_data,
    output logic [$clog2(ROWS)-1:0]      row_idx,
    output logic                         row_last,
    output logic [$clog2(ROWS*COLS):0]   pop_count,
    output logic                         done
);

    localparam int IDX_W = $clog2(ROWS);
    localparam int CNT_W = $clog2(ROWS * COLS) + 1;
    localparam int RPC_W = $clog2(COLS) + 1;

    state_t               state;
    state_t               state_next;
    logic [ROWS*COLS-1:0] snapshot;
    logic [IDX_W-1:0]     ptr;
    logic [CNT_W-1:0]     acc;
    logic [CNT_W-1:0]     acc_next;
    logic [COLS-1:0]      row_cur;
    logic [RPC_W-1:0]     row_pop;
    logic                 xfer;
    logic                 last_row;

    assign row_cur  = snapshot[ptr*COLS +: COLS];
    assign xfer     = (state == SEND) && row_ready;
    assign last_row = (ptr == IDX_W'(ROWS - 1));
    assign acc_next = acc + CNT_W'(row_pop);

    row_popcount #(
        .COLS (COLS)
    ) u_row_popcount (
        .row   (row_cur),
        .count (row_pop)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SEND;
            SEND:    if (xfer && last_row) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The final total is loaded on the last transfer so it lands in the same cycle as done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snapshot  <= '0;
            ptr       <= '0;
            acc       <= '0;
            pop_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snapshot <= board;
                        ptr      <= '0;
                        acc      <= '0;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        acc <= acc_next;
                        if (last_row) begin
                            pop_count <= acc_next;
                        end else begin
                            ptr <= ptr + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign row_valid = (state == SEND);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign row_data  = row_valid ? row_cur : '0;
    assign row_idx   = row_valid ? ptr : '0;
    assign row_last  = row_valid && last_row;

endmodule

// File: tb/tb_life_board_reader.sv
// Directed bench for life_board_reader: frames with hand-computed rows and
// populations, backpressure, ignored starts and an asynchronous mid-frame reset.
module tb_life_board_reader;

    logic         clk;
    logic         reset;
    logic         start;
    logic [255:0] board;
    logic         busy;
    logic         row_valid;
    logic         row_ready;
    logic [15:0]  row_data;
    logic [3:0]   row_idx;
    logic         row_last;
    logic [8:0]   pop_count;
    logic         done;

    int errors = 0;
    int checks = 0;

    life_board_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .board     (board),
        .busy      (busy),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .row_last  (row_last),
        .pop_count (pop_count),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // mode 0: ready held high; mode 1: ready 1,0,0,1 with board changed mid-frame;
    // mode 2: ready high with start pulsed during SEND.
    task automatic applyStimulus(input logic [255:0] b, input int mode,
                                 input logic [8:0] exp_pop, input string name);
        int r;
        int cyc;
        logic rdy;
        checkOutput($sformatf("%s idle valid", name), 32'(row_valid), 0);
        checkOutput($sformatf("%s idle busy", name), 32'(busy), 0);
        board = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r = 0;
        cyc = 0;
        while (r < 16 && cyc < 200) begin
            rdy = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            row_ready = rdy;
            if (mode == 1 && cyc == 1) board = ~b;
            start = (mode == 2) && (r == 5 || r == 10);
            checkOutput($sformatf("%s r%0d valid", name, r), 32'(row_valid), 1);
            checkOutput($sformatf("%s r%0d busy", name, r), 32'(busy), 1);
            checkOutput($sformatf("%s r%0d done", name, r), 32'(done), 0);
            checkOutput($sformatf("%s r%0d idx", name, r), 32'(row_idx), 32'(r));
            checkOutput($sformatf("%s r%0d data", name, r), 32'(row_data), 32'(b[r*16 +: 16]));
            checkOutput($sformatf("%s r%0d last", name, r), 32'(row_last), 32'(r == 15));
            @(negedge clk);
            cyc++;
            if (rdy) r++;
        end
        start = 1'b0;
        row_ready = 1'b0;
        if (r < 16) checkOutput($sformatf("%s timeout", name), 32'(r), 16);
        checkOutput($sformatf("%s done pulse", name), 32'(done), 1);
        checkOutput($sformatf("%s pop", name), 32'(pop_count), 32'(exp_pop));
        checkOutput($sformatf("%s done valid", name), 32'(row_valid), 0);
        checkOutput($sformatf("%s done busy", name), 32'(busy), 1);
        @(negedge clk);
        checkOutput($sformatf("%s post done", name), 32'(done), 0);
        checkOutput($sformatf("%s post busy", name), 32'(busy), 0);
        checkOutput($sformatf("%s pop hold", name), 32'(pop_count), 32'(exp_pop));
    endtask

    logic [255:0] glider;
    logic [255:0] ones;
    logic [255:0] walk;

    initial begin
        glider = '0;
        glider[15:0]  = 16'h0002;
        glider[31:16] = 16'h0004;
        glider[47:32] = 16'h0007;
        ones = '1;
        walk = '0;
        for (int i = 0; i < 16; i++) walk[i*16 +: 16] = 16'h0001 << i;

        reset = 1'b1;
        start = 1'b0;
        board = '0;
        row_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset valid", 32'(row_valid), 0);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset done", 32'(done), 0);
        checkOutput("reset pop", 32'(pop_count), 0);
        checkOutput("reset data", 32'(row_data), 0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus('0, 0, 9'd0, "empty");
        applyStimulus(glider, 2, 9'd5, "glider");
        applyStimulus(ones, 0, 9'd256, "ones");
        applyStimulus(walk, 1, 9'd16, "bp");

        board = ones;
        start = 1'b1;
        row_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && row_idx != 4'd7; k++) @(negedge clk);
        checkOutput("rst idx7 reached", 32'(row_idx), 7);
        #2 reset = 1'b1;
        #1;
        checkOutput("async valid", 32'(row_valid), 0);
        checkOutput("async busy", 32'(busy), 0);
        checkOutput("async done", 32'(done), 0);
        checkOutput("async pop", 32'(pop_count), 0);
        checkOutput("async idx", 32'(row_idx), 0);
        checkOutput("async data", 32'(row_data), 0);
        @(negedge clk);
        checkOutput("rst no done", 32'(done), 0);
        reset = 1'b0;
        row_ready = 1'b0;
        @(negedge clk);
        checkOutput("rst after done", 32'(done), 0);
        applyStimulus(glider, 0, 9'd5, "after rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
